// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch-request stage for Miniscule.
// Holds the PC, requests instruction words, and applies branch/jump redirects.
// Redirects that arrive while the PC cannot advance are held in a pending register.
// Optional build macro: PC_ALIGN_CHECK_EN. When it is defined, an odd jump target is refused.
// The PC then advances sequentially and align_err is set (sticky).
// When it is not defined, bit 0 of the jump target is dropped and align_err reads 0.
//
// Fetch handshake:
//   imem_req is high in FETCH, and comes from the registered state only.
//   A word is accepted on any edge where imem_req=1 and imem_ack=1.
//   If stall is also high, the PC is held and the stage parks in HOLD.
//   HOLD releases, and the PC advances, on the first edge with stall=0.
module pc_fetch_unit #(
   parameter int                  PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PC_WIDTH-1:0] branch_offset,
   input  logic                branch_taken,
   input  logic                jump_en,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                stall,
   input  logic                imem_ack,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_plus2,
   output logic                advance,
   output logic                flush,
   output logic                align_err
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [PC_WIDTH-1:0] C_TWO       = PC_WIDTH'(2);
   localparam logic [PC_WIDTH-1:0] C_LSB       = PC_WIDTH'(1);
   localparam logic [PC_WIDTH-1:0] C_RESET_PC2 = RESET_PC + C_TWO;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] r_pc_plus2;
   logic                r_advance;
   logic                r_flush;
   logic                r_pend_vld;
   logic [PC_WIDTH-1:0] r_pend_tgt;
   logic                r_pend_bad;

   logic                w_adv;
   logic                w_req;
   logic [PC_WIDTH-1:0] w_jump_tgt;
   logic                w_jump_bad;
   logic [PC_WIDTH-1:0] w_br_tgt;
   logic                w_take_bad;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic                w_redirect;
   logic [PC_WIDTH-1:0] w_cap_tgt;
   logic                w_cap_bad;

`ifdef PC_ALIGN_CHECK_EN
   logic                r_align_err;

   assign w_jump_tgt = jump_target;
   assign w_jump_bad = jump_target[0];
   assign align_err  = r_align_err;
`else
   // Bit 0 of the jump target is dropped, so every jump is taken.
   assign w_jump_tgt = jump_target & ~C_LSB;
   assign w_jump_bad = 1'b0;
   assign align_err  = 1'b0;
`endif

   // Branch target uses the pc_plus2 value that is current on this edge.
   assign w_br_tgt   = r_pc_plus2 + branch_offset;
   // A refused (misaligned) jump is the winning redirect source.
   assign w_take_bad = r_pend_vld ? r_pend_bad : (jump_en & w_jump_bad);
   // When both requests arrive on the same edge, the jump is the one captured.
   assign w_cap_tgt  = jump_en ? w_jump_tgt : w_br_tgt;
   assign w_cap_bad  = jump_en & w_jump_bad;

   assign imem_req = w_req;
   assign pc       = r_pc;
   assign pc_plus2 = r_pc_plus2;
   assign advance  = r_advance;
   assign flush    = r_flush;

   // FSM next state, advance event and fetch request
   always_comb begin
      w_state_nxt = r_state;
      w_adv       = 1'b0;
      w_req       = 1'b0;
      case (r_state)
         S_BOOT: w_state_nxt = S_FETCH;
         S_FETCH: begin
            w_req = 1'b1;
            if (imem_ack) begin
               if (stall) w_state_nxt = S_HOLD;
               else       w_adv       = 1'b1;
            end
         end
         S_HOLD: begin
            if (!stall) begin
               w_adv       = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_BOOT;
      endcase
   end

   // Next PC: pending redirect, then jump, then branch, then sequential
   always_comb begin
      w_pc_nxt   = r_pc_plus2;
      w_redirect = 1'b0;
      if (!w_take_bad) begin
         if (r_pend_vld) begin
            w_pc_nxt   = r_pend_tgt;
            w_redirect = 1'b1;
         end else if (jump_en) begin
            w_pc_nxt   = w_jump_tgt;
            w_redirect = 1'b1;
         end else if (branch_taken) begin
            w_pc_nxt   = w_br_tgt;
            w_redirect = 1'b1;
         end
      end
   end

   // State, PC, status pulses and pending-redirect register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_PC;
         r_pc_plus2 <= C_RESET_PC2;
         r_advance  <= 1'b0;
         r_flush    <= 1'b0;
         r_pend_vld <= 1'b0;
         r_pend_tgt <= '0;
         r_pend_bad <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_advance <= w_adv;
         r_flush   <= w_adv & w_redirect;
         if (w_adv) begin
            r_pc       <= w_pc_nxt;
            r_pc_plus2 <= w_pc_nxt + C_TWO;
            r_pend_vld <= 1'b0;
         end else if (jump_en || branch_taken) begin
            r_pend_vld <= 1'b1;
            r_pend_tgt <= w_cap_tgt;
            r_pend_bad <= w_cap_bad;
         end
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   // Sticky flag: set when a misaligned jump is refused
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_align_err <= 1'b0;
      else if (w_adv && w_take_bad) r_align_err <= 1'b1;
   end
`endif

endmodule
